counter_sequencer: RTL
======================

# counter_sequencer

Run controller for a cascaded prescaler/counter pair, where a fast counter's wrap enables a slow counter. Holds both counters inside the block and adds start/stop sequencing, programmable terminal values latched at start, and one-shot or periodic operation. Emits a registered prescaler tick and a period-done pulse for downstream logic. Replaces the hard-wired "fast counter all-ones enables slow counter" arrangement.

## Interface
- FAST_W, 4, width of the fast (prescaler) counter
- SLOW_W, 3, width of the slow (period) counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level, sampled each cycle; in IDLE, begins a run
- stop  in  1  abort; highest priority
- oneshot  in  1  sampled with start; 1 = single period, 0 = periodic
- fast_limit  in  FAST_W  fast terminal value, latched at start
- slow_limit  in  SLOW_W  slow terminal value, latched at start
- pause  in  1  hold counting (only with CNT_SEQ_PAUSE_EN)
- busy  out  1  high in RUN or PAUSED
- fast_cnt  out  FAST_W  fast counter value
- slow_cnt  out  SLOW_W  slow counter value
- tick  out  1  one-cycle pulse: fast counter wrapped
- done  out  1  one-cycle pulse: slow counter wrapped

## Operation
- States: IDLE, RUN, PAUSED (PAUSED exists only with the macro).
- Reset (rst_n low, asynchronous): state IDLE; busy, tick, done, fast_cnt, slow_cnt, latched limits and latched oneshot all 0.
- IDLE:
  - Counters hold 0.
  - start=1 and stop=0: latch fast_limit, slow_limit and oneshot; clear both counters; go to RUN.
- RUN, each edge:
  - If fast_cnt == fast_lim_q: fast_cnt<=0 and tick<=1.
    - If slow_cnt == slow_lim_q as well: slow_cnt<=0 and done<=1. If oneshot_q, go to IDLE.
    - Otherwise: slow_cnt<=slow_cnt+1.
  - Else: fast_cnt<=fast_cnt+1, and tick and done are 0.
- Arithmetic: both counters are unsigned and never exceed their latched limit.
  - fast_limit=0: tick on every cycle.
  - All-ones limits reproduce the free-running cascade.
- stop=1 in any state: go to IDLE on the next edge, clear both counters, force tick and done to 0. stop beats start, pause and wrap in the same cycle.
- start while busy: ignored. Limits stay latched, so input changes mid-run have no effect.
- One-shot completion: done and the IDLE transition happen on the same edge, so busy falls in the cycle where done is high.

## Timing
- Start sampled at edge E: busy=1 and counters=0 from E.
- First tick is high in the cycle after edge E+(fast_lim+1).
- Tick period = fast_lim+1 cycles.
- Done period = (fast_lim+1)*(slow_lim+1) cycles.
- First done is high after edge E+(fast_lim+1)*(slow_lim+1).
- tick and done are registered and never wider than one cycle unless the limit is 0; fast_limit=0 holds tick high continuously.
- Back-to-back run: in one-shot, if start is high in the cycle where done is high, the block re-enters RUN one edge later.

## Configuration
- CNT_SEQ_PAUSE_EN defined:
  - The pause port exists.
  - pause=1 in RUN: go to PAUSED on the next edge. Counters hold; tick and done are 0; busy stays 1.
  - pause=0 in PAUSED: return to RUN; counting resumes from the held values, so the period is extended by exactly the paused cycles.
  - pause is ignored in IDLE. stop aborts from PAUSED.
- CNT_SEQ_PAUSE_EN undefined: no pause port and no PAUSED state; RUN never holds.

## Test plan
- Periodic run, defaults, fast_limit=15, slow_limit=7, oneshot=0 -> tick every 16 cycles; slow_cnt steps 0..7; done every 128 cycles; busy stays 1.
- One-shot, fast_limit=2, slow_limit=1 -> ticks 3 and 6 cycles after the start edge; done coincides with the second tick; busy=0 in that same cycle; counters 0.
- fast_limit=0, slow_limit=3, periodic -> tick high continuously; done every 4 cycles.
- stop asserted at fast_cnt=9, slow_cnt=2, together with start -> next cycle IDLE, counters 0, no tick/done; later start restarts from 0.
- rst_n pulsed low mid-run -> all outputs 0 immediately, without waiting for a clock edge; after release the block stays IDLE until start.
- With CNT_SEQ_PAUSE_EN, fast_limit=3: pause for 5 cycles at fast_cnt=2 -> fast_cnt held at 2; the next tick arrives 5 cycles later than without pause.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Start/stop run controller for a cascaded prescaler (fast) and period (slow)
// counter pair. The fast counter wraps at a programmable terminal value and
// each wrap advances the slow counter; the slow wrap marks the end of a
// period. Terminal values and one-shot mode are captured when a run starts.
// Optional hold/resume support is compiled in with CNT_SEQ_PAUSE_EN.
module counter_sequencer #(
   parameter int FAST_W = 4,
   parameter int SLOW_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              oneshot,
   input  logic [FAST_W-1:0] fast_limit,
   input  logic [SLOW_W-1:0] slow_limit,
`ifdef CNT_SEQ_PAUSE_EN
   input  logic              pause,
`endif
   output logic              busy,
   output logic [FAST_W-1:0] fast_cnt,
   output logic [SLOW_W-1:0] slow_cnt,
   output logic              tick,
   output logic              done
);

`ifdef CNT_SEQ_PAUSE_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
`endif

   state_t state_reg;
   state_t state_next;

   // Counters, pulses and the run configuration captured at start
   logic [FAST_W-1:0] fast_reg;
   logic [FAST_W-1:0] fast_next;
   logic [SLOW_W-1:0] slow_reg;
   logic [SLOW_W-1:0] slow_next;
   logic              tick_reg;
   logic              tick_next;
   logic              done_reg;
   logic              done_next;
   logic [FAST_W-1:0] fast_lim_reg;
   logic [SLOW_W-1:0] slow_lim_reg;
   logic              oneshot_reg;

   // Control strobes from the FSM
   logic latch_en;
   logic count_en;

   // Terminal-value detection, built bitwise so it scales with the widths
   logic [FAST_W-1:0] fast_match;
   logic [SLOW_W-1:0] slow_match;
   logic              fast_wrap;
   logic              slow_wrap;

   genvar gi;
   generate
      for (gi = 0; gi < FAST_W; gi++) begin : g_fast_cmp
         assign fast_match[gi] = (fast_reg[gi] == fast_lim_reg[gi]);
      end
      for (gi = 0; gi < SLOW_W; gi++) begin : g_slow_cmp
         assign slow_match[gi] = (slow_reg[gi] == slow_lim_reg[gi]);
      end
   endgenerate

   assign fast_wrap = &fast_match;
   assign slow_wrap = &slow_match;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state, counter and pulse logic; stop overrides everything else
   always_comb begin
      state_next = state_reg;
      fast_next  = fast_reg;
      slow_next  = slow_reg;
      tick_next  = 1'b0;
      done_next  = 1'b0;
      latch_en   = 1'b0;
      count_en   = 1'b0;

      if (stop) begin
         state_next = ST_IDLE;
         fast_next  = '0;
         slow_next  = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               fast_next = '0;
               slow_next = '0;
               if (start) begin
                  latch_en   = 1'b1;
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
`ifdef CNT_SEQ_PAUSE_EN
               if (pause) begin
                  state_next = ST_PAUSED;
               end else begin
                  count_en = 1'b1;
               end
`else
               count_en = 1'b1;
`endif
            end
`ifdef CNT_SEQ_PAUSE_EN
            ST_PAUSED: begin
               // The resume edge counts, so the period grows by exactly the
               // number of edges on which pause was seen high.
               if (!pause) begin
                  state_next = ST_RUN;
                  count_en   = 1'b1;
               end
            end
`endif
            default: begin
               state_next = ST_IDLE;
            end
         endcase

         if (count_en) begin
            if (fast_wrap) begin
               fast_next = '0;
               tick_next = 1'b1;
               if (slow_wrap) begin
                  slow_next = '0;
                  done_next = 1'b1;
                  // One-shot ends on the same edge that raises done
                  if (oneshot_reg) begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  slow_next = slow_reg + 1'b1;
               end
            end else begin
               fast_next = fast_reg + 1'b1;
            end
         end
      end
   end

   // Counter and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fast_reg <= '0;
         slow_reg <= '0;
         tick_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         fast_reg <= fast_next;
         slow_reg <= slow_next;
         tick_reg <= tick_next;
         done_reg <= done_next;
      end
   end

   // Run configuration, captured only when a run is launched from IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fast_lim_reg <= '0;
         slow_lim_reg <= '0;
         oneshot_reg  <= 1'b0;
      end else if (latch_en) begin
         fast_lim_reg <= fast_limit;
         slow_lim_reg <= slow_limit;
         oneshot_reg  <= oneshot;
      end
   end

   assign busy     = (state_reg != ST_IDLE);
   assign fast_cnt = fast_reg;
   assign slow_cnt = slow_reg;
   assign tick     = tick_reg;
   assign done     = done_reg;

endmodule
